// File: rtl/fa_serial_ctrl.sv
// Bit-serial add sequencer for a single external full-adder cell, LSB first.
// Optional macro FA_SUB_EN adds a sub_i port for two's-complement subtraction.
module fa_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
`ifdef FA_SUB_EN
    input  logic             sub_i,
`endif
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_s_i,
    input  logic             fa_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   sum_sh;
    logic               carry;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

`ifdef FA_SUB_EN
    // Subtraction is A + ~B + 1; the forced carry-in supplies the +1.
    assign b_load     = sub_i ? ~op_b_i : op_b_i;
    assign carry_load = sub_i ? 1'b1 : cin_i;
`else
    assign b_load     = op_b_i;
    assign carry_load = cin_i;
`endif

    // The cell sees zeros outside RUN, so stale shifter/carry bits never leak.
    assign fa_a_o   = (state == RUN) & a_sh[0];
    assign fa_b_o   = (state == RUN) & b_sh[0];
    assign fa_cin_o = (state == RUN) & carry;

    // NOTE: every state element here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            sum_o  <= '0;
            cout_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        a_sh   <= op_a_i;
                        b_sh   <= b_load;
                        carry  <= carry_load;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the top; the final bit goes straight to sum_o.
                    sum_sh <= (WIDTH-1)'({fa_s_i, sum_sh} >> 1);
                    carry  <= fa_cout_i;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum_o  <= {fa_s_i, sum_sh};
                        cout_o <= fa_cout_i;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl with a behavioural full-adder cell.
// Define FA_SUB_EN for both files to exercise the subtract path.
module tb_fa_serial_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int BOUND = WIDTH + 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // External full-adder cell
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    fa_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .cin_i    (cin),
`ifdef FA_SUB_EN
        .sub_i    (sub),
`endif
        .fa_a_o   (fa_a),
        .fa_b_o   (fa_b),
        .fa_cin_o (fa_cin),
        .fa_s_i   (fa_s),
        .fa_cout_i(fa_cout),
        .busy_o   (busy),
        .done_o   (done),
        .sum_o    (sum),
        .cout_o   (cout)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic s);
        logic [WIDTH:0] t;
        exp_t e;
        if (s) t = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        else   t = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        return e;
    endfunction

    // Presents operands across one accept edge, then scrambles them.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic s);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        sb.push_back(model(a, b, c, s));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a  = WIDTH'($urandom);
        op_b  = WIDTH'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    // Counts edges after the accept edge until done_o is seen.
    task automatic wait_done(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, cout, fa_a, fa_b, fa_cin} !== 6'b0)
            $display("FAIL reset_ctrl: busy/done/cout/fa = %b, want 000000",
                     {busy, done, cout, fa_a, fa_b, fa_cin});
        else pass_cnt++;
        chk_cnt++;
        if (sum !== '0) $display("FAIL reset_sum: got %h want 00", sum);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic c, input logic s);
        int   n;
        bit   ok;
        exp_t e;
        start_op(a, b, c, s);
        wait_done(n, ok);
        chk_cnt++;
        if (!ok) begin
            $display("FAIL %s_timeout: no done_o within %0d edges", name, BOUND);
            void'(sb.pop_front());
            return;
        end
        pass_cnt++;
        e = sb.pop_front();
        chk_cnt++;
        if (n !== WIDTH) $display("FAIL %s_latency: got %0d edges want %0d", name, n, WIDTH);
        else pass_cnt++;
        chk_cnt++;
        if ({cout, sum} !== {e.cout, e.sum})
            $display("FAIL %s_result: got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, e.cout, e.sum);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({done, busy} !== 2'b00)
            $display("FAIL %s_pulse: done/busy=%b one cycle later, want 00", name, {done, busy});
        else pass_cnt++;
    endtask

    task automatic test_add;
        run_and_check("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0);
        run_and_check("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_and_check("cin_00_00", 8'h00, 8'h00, 1'b1, 1'b0);
        run_and_check("all_ones", 8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_and_check("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_start_busy;
        int   dones = 0;
        int   gaps  = 0;
        exp_t e;
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        for (int n = 1; n <= WIDTH + 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) begin
                start = 1'b1;
                op_a  = 8'hAA;
                op_b  = 8'h55;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                e = sb.pop_front();
                chk_cnt++;
                if ({cout, sum} !== {e.cout, e.sum})
                    $display("FAIL busy_start_result: got cout=%b sum=%h want cout=%b sum=%h",
                             cout, sum, e.cout, e.sum);
                else pass_cnt++;
            end
            if (n <= WIDTH && !busy) gaps++;
        end
        chk_cnt++;
        if (gaps !== 0) $display("FAIL busy_start_busy: busy_o dropped %0d times, want 0", gaps);
        else pass_cnt++;
        chk_cnt++;
        if (dones !== 1) $display("FAIL busy_start_dones: got %0d done pulses want 1", dones);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL busy_start_idle: busy_o=%b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        start_op(8'h77, 8'h11, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk_cnt++;
        if ({busy, done, cout, fa_a, fa_b, fa_cin} !== 6'b0)
            $display("FAIL midreset_ctrl: busy/done/cout/fa = %b want 000000",
                     {busy, done, cout, fa_a, fa_b, fa_cin});
        else pass_cnt++;
        chk_cnt++;
        if (sum !== '0) $display("FAIL midreset_sum: got %h want 00", sum);
        else pass_cnt++;
        repeat (2 * WIDTH) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        chk_cnt++;
        if (dones !== 0) $display("FAIL midreset_done: got %0d done pulses want 0", dones);
        else pass_cnt++;
        run_and_check("after_reset", 8'h3C, 8'hC4, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
`ifdef FA_SUB_EN
        run_and_check("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
        run_and_check("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1);
`endif
    endtask

    task automatic test_back_to_back;
        int   cyc      = 0;
        int   last_acc = 0;
        int   accepts  = 0;
        int   dones    = 0;
        logic prev_busy;
        exp_t e;
        @(negedge clk);
        prev_busy = busy;
        op_a  = 8'hC3;
        op_b  = 8'h5A;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 6 * (WIDTH + 2); i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busy && !prev_busy) begin
                sb.push_back(model(op_a, op_b, cin, 1'b0));
                if (accepts > 0) begin
                    chk_cnt++;
                    if (cyc - last_acc !== WIDTH + 2)
                        $display("FAIL b2b_interval: got %0d cycles want %0d",
                                 cyc - last_acc, WIDTH + 2);
                    else pass_cnt++;
                end
                last_acc = cyc;
                accepts++;
                op_a = WIDTH'($urandom);
                op_b = WIDTH'($urandom);
                cin  = 1'($urandom);
                if (accepts == 4) start = 1'b0;
            end
            if (!busy) begin
                chk_cnt++;
                if ({fa_a, fa_b, fa_cin} !== 3'b000)
                    $display("FAIL b2b_idle_fa: fa a/b/cin=%b in IDLE want 000",
                             {fa_a, fa_b, fa_cin});
                else pass_cnt++;
            end
            if (done) begin
                dones++;
                e = sb.pop_front();
                chk_cnt++;
                if ({cout, sum} !== {e.cout, e.sum})
                    $display("FAIL b2b_result: got cout=%b sum=%h want cout=%b sum=%h",
                             cout, sum, e.cout, e.sum);
                else pass_cnt++;
            end
            prev_busy = busy;
            if (dones == 4) break;
        end
        start = 1'b0;
        chk_cnt++;
        if (dones !== 4) $display("FAIL b2b_count: got %0d results want 4", dones);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_start_busy();
        test_reset_mid();
        test_sub();
        test_back_to_back();
        chk_cnt++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
